// File: rtl/fifo_rd_axis_pkg.sv
// Shared helpers for the FIFO read-side AXI-Stream adapter: counter sizing
// and parameter legality.
package fifo_rd_axis_pkg;

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int buf_depth, input int read_latency);
        return (buf_depth >= 1) && (read_latency >= 1);
    endfunction

endpackage

// File: rtl/fifo_rd_axis_if.sv
// AXI-Stream valid/ready/data bundle between the read adapter and its sink.
interface fifo_rd_axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fifo_rd_buf.sv
// Register-based circular buffer that lands FIFO read data and presents a
// registered head word; clr_i empties it synchronously.
module fifo_rd_buf
    import fifo_rd_axis_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 2,
    localparam int CNT_W      = calc_cnt_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CNT_W-1:0]      level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      level_q, level_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en_i) rd_ptr_d = ptr_inc(rd_ptr_q);
            level_d = level_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/fifo_rd_axis.sv
// FIFO read-side adapter: issues credit-limited pops, tracks the fixed read
// latency with a tag pipe and streams buffered words out as AXI-Stream.
module fifo_rd_axis
    import fifo_rd_axis_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int READ_LATENCY = 1,
    parameter  int BUF_DEPTH    = READ_LATENCY + 1,
    localparam int LVL_W        = calc_cnt_w(BUF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_pop_o,
    fifo_rd_axis_if.master        m_axis,
    output logic [LVL_W-1:0]      level_o
);

    localparam int CMT_W = $clog2(BUF_DEPTH + READ_LATENCY + 1);
    localparam int CMP_W = CMT_W + 1;

    if (!params_ok(BUF_DEPTH, READ_LATENCY)) begin : g_param_check
        $error("fifo_rd_axis: BUF_DEPTH and READ_LATENCY must both be >= 1");
    end

    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic [CMT_W-1:0]        inflight;
    logic [CMT_W-1:0]        committed;
    logic [LVL_W-1:0]        level;
    logic [DATA_WIDTH-1:0]   head;
    logic                    fire;
    logic                    capture;
    logic                    pop;

    assign fire    = m_axis.tvalid & m_axis.tready;
    assign capture = tag_q[READ_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CMT_W'(tag_q[i]);
    end

    assign committed = CMT_W'(level) + inflight;

    // A word leaving this cycle frees its slot, so the credit test adds fire
    // on the right-hand side rather than subtracting it from committed.
    assign pop = rstn_i & ~fifo_empty_i & ~flush_i &
                 ({1'b0, committed} < (CMP_W'(BUF_DEPTH) + CMP_W'(fire)));

    always_comb begin
        tag_d = '0;
        if (!flush_i) begin
            tag_d[0] = pop;
            for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) tag_q <= '0;
        else         tag_q <= tag_d;
    end

    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (flush_i),
        .wr_en_i   (capture & ~flush_i),
        .wr_data_i (fifo_rd_data_i),
        .rd_en_i   (fire),
        .head_o    (head),
        .level_o   (level)
    );

    assign fifo_pop_o    = pop;
    assign m_axis.tvalid = (level != '0);
    assign m_axis.tdata  = head;
    assign level_o       = level;

endmodule
